// File: rtl/am2910_pkg.sv
// Shared types and defaults for the Am2910 microprogram sequencer.
package am2910_pkg;

    localparam int unsigned WIDTH_DEF = 12;
    localparam int unsigned DEPTH_DEF = 5;

    typedef enum logic [3:0] {
        JZ   = 4'd0,
        CJS  = 4'd1,
        JMAP = 4'd2,
        CJP  = 4'd3,
        PUSH = 4'd4,
        JSRP = 4'd5,
        CJV  = 4'd6,
        JRP  = 4'd7,
        RFCT = 4'd8,
        RPCT = 4'd9,
        CRTN = 4'd10,
        CJPP = 4'd11,
        LDCT = 4'd12,
        LOOP = 4'd13,
        CONT = 4'd14,
        TWB  = 4'd15
    } opcodeT;

    typedef enum logic [2:0] {
        YSRC_UPC  = 3'd0,
        YSRC_D    = 3'd1,
        YSRC_R    = 3'd2,
        YSRC_TOS  = 3'd3,
        YSRC_ZERO = 3'd4
    } ySrcT;

endpackage

// File: rtl/am2910_stack.sv
// LIFO subroutine/loop stack; a push when full overwrites the top entry.
module am2910_stack
    import am2910_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tos,
    output logic             full
);

    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp;

    // Stack pointer and storage update; clear beats push beats pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            sp <= '0;
        end else if (push) begin
            if (sp == SPW'(DEPTH)) begin
                mem[AW'(DEPTH - 1)] <= din;
            end else begin
                mem[AW'(sp)] <= din;
                sp           <= sp + 1'b1;
            end
        end else if (pop && (sp != '0)) begin
            sp <= sp - 1'b1;
        end
    end

    // Top-of-stack read; an empty stack reads as zero.
    always_comb begin
        tos = '0;
        if (sp != '0) begin
            tos = mem[AW'(sp - 1'b1)];
        end
    end

    assign full = (sp == SPW'(DEPTH));

endmodule

// File: rtl/am2910_seq.sv
// Am2910 microprogram sequencer: instruction decode, Y mux, uPC and R counter.
module am2910_seq
    import am2910_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    input  logic [3:0]       I,
    input  logic             nCCEN,
    input  logic             nCC,
    input  logic             nRLD,
    input  logic             CI,
    output logic [WIDTH-1:0] Y,
    output logic             nPL,
    output logic             nMAP,
    output logic             nVECT,
    output logic             nFULL
);

    logic [WIDTH-1:0] uPC;
    logic [WIDTH-1:0] rCnt;
    logic [WIDTH-1:0] tos;
    logic             stkFull;
    logic             pass;
    logic             rNz;
    opcodeT           op;
    ySrcT             ySrc;
    logic             push;
    logic             pop;
    logic             clear;
    logic             rLoad;
    logic             rDec;

    assign op   = opcodeT'(I);
    assign pass = nCCEN | ~nCC;
    assign rNz  = (rCnt != '0);

    // Instruction decode: Y source and stack/counter actions.
    always_comb begin
        ySrc  = YSRC_UPC;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        rLoad = 1'b0;
        rDec  = 1'b0;
        case (op)
            JZ:   begin ySrc = YSRC_ZERO; clear = 1'b1; end
            CJS:  if (pass) begin ySrc = YSRC_D; push = 1'b1; end
            JMAP: ySrc = YSRC_D;
            CJP:  if (pass) ySrc = YSRC_D;
            PUSH: begin push = 1'b1; rLoad = pass; end
            JSRP: begin push = 1'b1; ySrc = pass ? YSRC_D : YSRC_R; end
            CJV:  if (pass) ySrc = YSRC_D;
            JRP:  ySrc = pass ? YSRC_D : YSRC_R;
            RFCT: if (rNz) begin ySrc = YSRC_TOS; rDec = 1'b1; end
                  else pop = 1'b1;
            RPCT: if (rNz) begin ySrc = YSRC_D; rDec = 1'b1; end
            CRTN: if (pass) begin ySrc = YSRC_TOS; pop = 1'b1; end
            CJPP: if (pass) begin ySrc = YSRC_D; pop = 1'b1; end
            LDCT: rLoad = 1'b1;
            LOOP: if (pass) pop = 1'b1;
                  else ySrc = YSRC_TOS;
            CONT: ySrc = YSRC_UPC;
            TWB: begin
                if (rNz) begin
                    rDec = 1'b1;
                    if (pass) pop = 1'b1;
                    else ySrc = YSRC_TOS;
                end else begin
                    pop = 1'b1;
                    if (!pass) ySrc = YSRC_D;
                end
            end
        endcase
    end

    // Next-address mux; forced to zero while in reset.
    always_comb begin
        Y = '0;
        if (!reset) begin
            case (ySrc)
                YSRC_UPC: Y = uPC;
                YSRC_D:   Y = D;
                YSRC_R:   Y = rCnt;
                YSRC_TOS: Y = tos;
                default:  Y = '0;
            endcase
        end
    end

    // D-source strobes and stack-full flag.
    always_comb begin
        nPL   = 1'b0;
        nMAP  = 1'b1;
        nVECT = 1'b1;
        nFULL = 1'b1;
        if (!reset) begin
            nMAP  = (op != JMAP);
            nVECT = (op != CJV);
            nPL   = (op == JMAP) || (op == CJV);
            nFULL = ~stkFull;
        end
    end

    // Microprogram counter follows Y plus carry-in.
    always_ff @(posedge clk) begin
        if (reset) begin
            uPC <= '0;
        end else begin
            uPC <= Y + WIDTH'(CI);
        end
    end

    // Loop/repeat counter; an external load wins over decode actions.
    always_ff @(posedge clk) begin
        if (reset) begin
            rCnt <= '0;
        end else if (!nRLD || rLoad) begin
            rCnt <= D;
        end else if (rDec) begin
            rCnt <= rCnt - 1'b1;
        end
    end

    am2910_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) uStack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (uPC),
        .tos   (tos),
        .full  (stkFull)
    );

endmodule
